// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, redirect controls from
// hazard/EX, and the IF/ID register outputs toward decode.
interface fetch_unit_if #(
    parameter int unsigned BIT_WIDTH = 32
) ();
    logic [BIT_WIDTH-1:0] pc_out;
    logic [BIT_WIDTH-1:0] inst_in;
    logic                 stall;
    logic                 branch_taken;
    logic [BIT_WIDTH-1:0] branch_target;
    logic                 exception;
    logic [BIT_WIDTH-1:0] if_id_pc;
    logic [BIT_WIDTH-1:0] if_id_inst;
    logic                 if_id_valid;
    logic                 halted;
    logic [BIT_WIDTH-1:0] fetch_count;

    modport slave (
        output pc_out, if_id_pc, if_id_inst, if_id_valid, halted, fetch_count,
        input  inst_in, stall, branch_taken, branch_target, exception
    );

    modport master (
        input  pc_out, if_id_pc, if_id_inst, if_id_valid, halted, fetch_count,
        output inst_in, stall, branch_taken, branch_target, exception
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the memory word into IF/ID,
// and handles stall, branch/exception redirect and hlt freezing.
//
//   state | meaning
//   RUN   | fetching sequentially, PC advances each unstalled cycle
//   HALT  | hlt delivered; PC frozen, IF/ID fed bubbles until a redirect
module fetch_unit #(
    parameter int unsigned          BIT_WIDTH  = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [BIT_WIDTH-1:0] EXC_VECTOR = BIT_WIDTH'(254),
    parameter logic [5:0]           HLT_OPCODE = 6'h3F
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t               state_q,  state_d;
    logic [BIT_WIDTH-1:0] pc_q,     pc_d;
    logic [BIT_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic [BIT_WIDTH-1:0] ifid_inst_q, ifid_inst_d;
    logic                 ifid_valid_q, ifid_valid_d;
    logic [BIT_WIDTH-1:0] count_q,  count_d;
    logic                 is_hlt;

    assign is_hlt = (bus.inst_in[BIT_WIDTH-1 -: 6] == HLT_OPCODE);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;
        count_d      = count_q;

        if (bus.exception) begin
            pc_d         = EXC_VECTOR;
            ifid_pc_d    = '0;
            ifid_inst_d  = '0;
            ifid_valid_d = 1'b0;
            state_d      = RUN;
        end else if (bus.branch_taken) begin
            pc_d         = bus.branch_target;
            ifid_pc_d    = '0;
            ifid_inst_d  = '0;
            ifid_valid_d = 1'b0;
            state_d      = RUN;
        end else if (bus.stall) begin
            // everything holds; defaults already cover it
        end else if (state_q == HALT) begin
            ifid_pc_d    = '0;
            ifid_inst_d  = '0;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_pc_d    = pc_q;
            ifid_inst_d  = bus.inst_in;
            ifid_valid_d = 1'b1;
            count_d      = count_q + 1'b1;
            if (is_hlt) begin
                state_d = HALT;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_inst_q  <= '0;
            ifid_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
            count_q      <= count_d;
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.if_id_pc    = ifid_pc_q;
    assign bus.if_id_inst  = ifid_inst_q;
    assign bus.if_id_valid = ifid_valid_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.fetch_count = count_q;
endmodule
